// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer states and status codes for the ALU op sequencer.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_ILL  = 2'b01;
  localparam logic [1:0] ERR_DIV0 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOADY,
    S_EXEC,
    S_RESP
  } state_t;

  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    logic ok;
    unique case (1'b1)
      (op >= OP_ADD) && (op <= OP_ROL): ok = 1'b1;
      (op >= OP_MUL) && (op <= OP_NOT): ok = 1'b1;
      default:                          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_shift(input logic [4:0] op);
    return (op >= OP_SHR) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/alu_seq_cycle_counter.sv
// Load/decrement counter timing the EXEC phase; done when it reaches zero.
module alu_seq_cycle_counter (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one ALU op per request and returns Z as LO/HI plus status.
// ALU_SEQ_SHAMT_MASK_EN: mask shift amounts on the bus to B[4:0].
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int EXEC_CYCLES   = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_y,
  output logic [31:0] alu_bus,
  output logic [4:0]  alu_ctrl,
  output logic        alu_in,
  input  logic [63:0] alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic [1:0]  rsp_err
);

  localparam logic [3:0] LD_NARROW = 4'(EXEC_CYCLES - 1);
  localparam logic [3:0] LD_WIDE   = 4'(MULDIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [4:0]  op_q;
  logic [31:0] a_q, b_q, lo_q, hi_q;
  logic [1:0]  err_q;
  logic        cnt_load, cnt_dec, cnt_done;
  logic [3:0]  cnt_val;
  logic [31:0] bus_exec;
  logic        bad_op, div0, accept, finish;

  assign bad_op = !is_legal(req_op);
  assign div0   = (req_op == OP_DIV) && (req_b == 32'd0);
  assign accept = (state == S_IDLE) && req_valid;
  assign finish = (state == S_EXEC) && cnt_done;

`ifdef ALU_SEQ_SHAMT_MASK_EN
  assign bus_exec = is_shift(op_q) ? {27'b0, b_q[4:0]} : b_q;
`else
  assign bus_exec = b_q;
`endif

  alu_seq_cycle_counter u_cnt (
    .clock    (clock),
    .clear    (clear),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_y     = 32'd0;
    alu_bus   = 32'd0;
    alu_ctrl  = 5'd0;
    alu_in    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = is_wide(op_q) ? LD_WIDE : LD_NARROW;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (bad_op || div0) ? S_RESP : S_LOADY;
      end
      S_LOADY: begin
        alu_y     = a_q;
        cnt_load  = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        alu_y    = a_q;
        alu_bus  = bus_exec;
        alu_ctrl = op_q;
        alu_in   = 1'b1;
        if (cnt_done) state_nxt = S_RESP;
        else          cnt_dec   = 1'b1;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Upper Z is only meaningful for mul/div; drop it for everything else.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      op_q  <= 5'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      lo_q  <= 32'd0;
      hi_q  <= 32'd0;
      err_q <= ERR_OK;
    end else if (accept) begin
      op_q  <= req_op;
      a_q   <= req_a;
      b_q   <= req_b;
      lo_q  <= 32'd0;
      hi_q  <= 32'd0;
      err_q <= bad_op ? ERR_ILL :
               div0   ? ERR_DIV0 : ERR_OK;
    end else if (finish) begin
      lo_q <= alu_z[31:0];
      hi_q <= is_wide(op_q) ? alu_z[63:32] : 32'd0;
    end
  end

  assign rsp_lo  = lo_q;
  assign rsp_hi  = hi_q;
  assign rsp_err = err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the Z side.
module tb_alu_op_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [31:0] alu_y, alu_bus;
  logic [4:0]  alu_ctrl;
  logic        alu_in;
  logic [63:0] alu_z;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_lo, rsp_hi;
  logic [1:0]  rsp_err;

  int n_vec = 0;
  int n_mis = 0;
  int lat, nin;
  logic [31:0] y1, bus1, bus_ex;
  logic [4:0]  ctrl_ex;

  always #5 clock = ~clock;

  alu_op_sequencer dut (
    .clock     (clock),
    .clear     (clear),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_y     (alu_y),
    .alu_bus   (alu_bus),
    .alu_ctrl  (alu_ctrl),
    .alu_in    (alu_in),
    .alu_z     (alu_z),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_lo    (rsp_lo),
    .rsp_hi    (rsp_hi),
    .rsp_err   (rsp_err)
  );

  // Junk in Z[63:32] for single-word ops so a leaked HI is visible.
  always_comb begin
    alu_z = {32'hA5A5A5A5, 32'd0};
    unique case (alu_ctrl)
      5'b00011: alu_z[31:0] = alu_y + alu_bus;
      5'b00100: alu_z[31:0] = alu_y - alu_bus;
      5'b00101: alu_z[31:0] = alu_y & alu_bus;
      5'b00110: alu_z[31:0] = alu_y | alu_bus;
      5'b00111: alu_z[31:0] = alu_y >> alu_bus;
      5'b01000: alu_z[31:0] = $signed(alu_y) >>> alu_bus;
      5'b01001: alu_z[31:0] = alu_y << alu_bus;
      5'b01010: alu_z[31:0] = (alu_y >> alu_bus[4:0]) |
                              (alu_y << (6'd32 - {1'b0, alu_bus[4:0]}));
      5'b01011: alu_z[31:0] = (alu_y << alu_bus[4:0]) |
                              (alu_y >> (6'd32 - {1'b0, alu_bus[4:0]}));
      5'b01111: alu_z = 64'($signed(alu_y) * $signed(alu_bus));
      5'b10000: alu_z = (alu_bus == 0) ? 64'd0 :
                        {alu_y % alu_bus, alu_y / alu_bus};
      5'b10001: alu_z[31:0] = -alu_bus;
      5'b10010: alu_z[31:0] = ~alu_bus;
      default:  alu_z = 64'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clock);
    chk("idle_ready", 64'(req_ready), 1);
    chk("idle_rsp", 64'(rsp_valid), 0);
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    nin = 0;
    y1 = 32'hx;
    bus1 = 32'hx;
    bus_ex = 32'd0;
    ctrl_ex = 5'd0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clock);
      if (c == 1) begin
        y1 = alu_y;
        bus1 = alu_bus;
      end
      if (rsp_valid) lat = c;
      else if (alu_in) begin
        nin++;
        bus_ex = alu_bus;
        ctrl_ex = alu_ctrl;
      end
    end
    if (lat == 0) chk("rsp_timeout", 64'(rsp_valid), 1);
    chk("resp_ready_low", 64'(req_ready), 0);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{5'b00011, 32'd5, 32'd7, 32'd12};
    vt[1] = '{5'b00100, 32'd10, 32'd3, 32'd7};
    vt[2] = '{5'b00101, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00};
    vt[3] = '{5'b00110, 32'hF0000000, 32'h0000000F, 32'hF000000F};
    vt[4] = '{5'b01000, 32'h80000000, 32'd4, 32'hF8000000};
    vt[5] = '{5'b01010, 32'd1, 32'd1, 32'h80000000};
    vt[6] = '{5'b10010, 32'd0, 32'h0F0F0F0F, 32'hF0F0F0F0};
    vt[7] = '{5'b10001, 32'd0, 32'd5, 32'hFFFFFFFB};

    #2;
    chk("rst_valid", 64'(rsp_valid), 0);
    chk("rst_alu_in", 64'(alu_in), 0);
    chk("rst_y", 64'(alu_y), 0);
    chk("rst_lo", 64'(rsp_lo), 0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    chk("rst_ready", 64'(req_ready), 1);

    for (int i = 0; i < 8; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_lat", i), 64'(lat), 3);
      chk($sformatf("v%0d_lo", i), 64'(rsp_lo), 64'(vt[i].lo));
      chk($sformatf("v%0d_hi", i), 64'(rsp_hi), 0);
      chk($sformatf("v%0d_err", i), 64'(rsp_err), 0);
      chk($sformatf("v%0d_nin", i), 64'(nin), 1);
      chk($sformatf("v%0d_ctrl", i), 64'(ctrl_ex), 64'(vt[i].op));
      handshake();
    end

    issue(5'b00011, 32'd5, 32'd7);
    chk("add_loady_y", 64'(y1), 5);
    chk("add_loady_bus", 64'(bus1), 0);
    handshake();

    issue(5'b01111, 32'hFFFFFFFF, 32'd3);
    chk("mul_lat", 64'(lat), 6);
    chk("mul_nin", 64'(nin), 4);
    chk("mul_lo", 64'(rsp_lo), 64'hFFFFFFFD);
    chk("mul_hi", 64'(rsp_hi), 64'hFFFFFFFF);
    handshake();

    issue(5'b10000, 32'd17, 32'd5);
    chk("div_lat", 64'(lat), 6);
    chk("div_lo", 64'(rsp_lo), 3);
    chk("div_hi", 64'(rsp_hi), 2);
    chk("div_err", 64'(rsp_err), 0);
    handshake();

    issue(5'b10000, 32'd17, 32'd0);
    chk("div0_lat", 64'(lat), 1);
    chk("div0_err", 64'(rsp_err), 2);
    chk("div0_lo", 64'(rsp_lo), 0);
    chk("div0_hi", 64'(rsp_hi), 0);
    chk("div0_nin", 64'(nin), 0);
    handshake();

    issue(5'b00000, 32'd1, 32'd2);
    chk("ill_lat", 64'(lat), 1);
    chk("ill_err", 64'(rsp_err), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("stall_valid", 64'(rsp_valid), 1);
      chk("stall_err", 64'(rsp_err), 1);
      chk("stall_lo", 64'(rsp_lo), 0);
      chk("stall_ready", 64'(req_ready), 0);
      chk("stall_alu_in", 64'(alu_in), 0);
    end
    handshake();

    issue(5'b01001, 32'd1, 32'd33);
`ifdef ALU_SEQ_SHAMT_MASK_EN
    chk("shl_bus", 64'(bus_ex), 1);
    chk("shl_lo", 64'(rsp_lo), 2);
`else
    chk("shl_bus", 64'(bus_ex), 33);
    chk("shl_lo", 64'(rsp_lo), 0);
`endif
    handshake();

    @(negedge clock);
    req_valid = 1'b1;
    req_op = 5'b01111;
    req_a = 32'd9;
    req_b = 32'd9;
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("clr_pre_in", 64'(alu_in), 1);
    #2 clear = 1'b0;
    #1;
    chk("clr_alu_in", 64'(alu_in), 0);
    chk("clr_y", 64'(alu_y), 0);
    chk("clr_bus", 64'(alu_bus), 0);
    chk("clr_ctrl", 64'(alu_ctrl), 0);
    chk("clr_valid", 64'(rsp_valid), 0);
    chk("clr_lo", 64'(rsp_lo), 0);
    @(negedge clock);
    clear = 1'b1;

    issue(5'b00011, 32'd20, 32'd22);
    chk("post_lat", 64'(lat), 3);
    chk("post_lo", 64'(rsp_lo), 42);
    chk("post_hi", 64'(rsp_hi), 0);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
